// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, reads the synchronous instruction
// memory and buffers returned words in a DEPTH-entry FIFO for the IF/ID register.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;

  logic [31:0]   fpc;
  logic [31:0]   resp_pc;
  logic          inflight;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic [CW1-1:0] used;
  logic           push;
  logic           pop;

  // Handshake: id_valid/id_instr/id_pc describe the head entry; an entry is consumed
  // at a rising edge where id_valid && id_ready. id_valid never depends on id_ready.

  // Credits: occupied entries plus the one response that may still be returning.
  assign used      = CW1'(count) + CW1'(inflight);
  assign imem_req  = !rst && !redirect && (used < CW1'(DEPTH));
  assign imem_addr = fpc;

  // A response landing in a redirect cycle belongs to the abandoned path.
  assign push = inflight && !redirect;
  assign pop  = id_valid && id_ready;

  assign id_valid = (count != '0);
  assign id_instr = instr_mem[rd_ptr];
  assign id_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fpc      <= redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        fpc      <= fpc + 32'd1;
        resp_pc  <= fpc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random ready/redirect traffic, checked
// every cycle against a queue-based model of the fetch front end.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] exp_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_resp;
  logic        m_infl;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous instruction memory: data for a request appears the next cycle.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_fpc  = 32'h0;
    m_resp = 32'h0;
    m_infl = 1'b0;
  endfunction

  function automatic logic model_req(input logic red);
    return !red && ((exp_q.size() + int'(m_infl)) < DEPTH);
  endfunction

  // Called at a negedge: drive, compare, advance one clock, update model, return at negedge.
  task automatic step(input logic red, input logic [31:0] rpc, input logic rdy);
    logic req;
    logic pop;
    redirect    = red;
    redirect_pc = rpc;
    id_ready    = rdy;
    #1;
    req = model_req(red);
    pop = (exp_q.size() != 0) && rdy;
    chk("imem_req", {31'b0, imem_req}, {31'b0, req});
    if (req) chk("imem_addr", imem_addr, m_fpc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
    chk("count", {29'b0, count}, 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      chk("id_pc", id_pc, exp_q[0]);
      chk("id_instr", id_instr, mem_word(exp_q[0]));
    end
    @(posedge clk);
    if (red) begin
      exp_q.delete();
      m_fpc  = rpc;
      m_infl = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_infl) exp_q.push_back(m_resp);
      if (req) begin
        m_resp = m_fpc;
        m_fpc  = m_fpc + 32'd1;
        m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;
    imem_rdata  = 32'h0;
    model_reset();

    // Reset, then free-running stream from RESET_PC
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    // Back-pressure from reset fills the queue, then drains without gaps
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
    chk("stall_full_count", {29'b0, count}, 32'd4);
    chk("stall_head_pc", id_pc, 32'h0);
    chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect during steady streaming
    step(1'b1, 32'h40, 1'b1);
    chk("redir_addr", imem_addr, 32'h40);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Redirect while full and stalled
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h10, 1'b0);
    chk("redir_full_count", {29'b0, count}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: last wins
    step(1'b1, 32'h20, 1'b1);
    step(1'b1, 32'h30, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 12 && exp_q.size() != 3; i++) step(1'b0, 32'h0, 1'b0);
    chk("pre_reset_count", {29'b0, count}, 32'd3);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Fetch PC wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Random ready and redirect traffic
    for (int i = 0; i < 500; i++) begin
      logic        red;
      logic [31:0] rpc;
      red = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 4095));
      step(red, rpc, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
